// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM state encoding and oversampling default for the UART receiver
package uart_rx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;
  localparam int OVERSAMPLE_DEF = 16;
endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: free-running divider emitting a one-cycle tick every CLK_DIV cycles
module uart_rx_tick #(
  parameter int CLK_DIV = 21
) (
  input  logic clk2,
  input  logic rst,
  output logic tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == W'(CLK_DIV - 1);
    cnt_d = tick ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge clk2) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampling, mid-bit sampling, single-byte holding register
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int FRQ        = 40000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CLK_DIV = FRQ / (BAUD_RATE * OVERSAMPLE);
  logic [1:0] sync_q, sync_d;
  logic       rx_s, tick, deliver;
  state_e     state_q, state_d;
  logic [3:0] s_cnt_q, s_cnt_d;
  logic [2:0] b_cnt_q, b_cnt_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  uart_rx_tick #(.CLK_DIV(CLK_DIV)) u_tick (.clk2(clk2), .rst(rst), .tick(tick));
  assign rx_s = sync_q[1];
  always_comb begin
    sync_d      = {sync_q[0], rx};
    state_d     = state_q;
    s_cnt_d     = tick ? s_cnt_q + 4'd1 : s_cnt_q;
    b_cnt_d     = b_cnt_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
        START: if (s_cnt_q == 4'd7) begin
          state_d = rx_s ? IDLE : DATA;
          s_cnt_d = '0;
          b_cnt_d = '0;
        end
        DATA: if (s_cnt_q == 4'd15) begin
          shift_d = {rx_s, shift_q[7:1]};
          s_cnt_d = '0;
          state_d = b_cnt_q == 3'd7 ? STOP : DATA;
          b_cnt_d = b_cnt_q + 3'd1;
        end
        STOP: if (s_cnt_q == 4'd15) begin
          state_d     = IDLE;
          s_cnt_d     = '0;
          deliver     = rx_s;
          frame_err_d = !rx_s;
        end
        default: state_d = IDLE;
      endcase
    end
    // a full, unconsumed holding register wins over a new byte
    rx_data_d  = (deliver && (!rx_valid_q || rx_ready)) ? shift_q : rx_data_q;
    rx_valid_d = deliver | (rx_valid_q & ~rx_ready);
    overrun_d  = deliver & rx_valid_q & ~rx_ready;
  end
  always_ff @(posedge clk2) begin
    if (rst) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      b_cnt_q     <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      b_cnt_q     <= b_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = state_q != IDLE;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FRQ, default 40000000, meaning receiver clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit; only 16 is supported.
REQ-004 SHALL have derived constant CLK_DIV = FRQ/(BAUD_RATE*OVERSAMPLE), integer division (21 at defaults).
REQ-005 clk2  input  1  receiver clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rx  input  1  asynchronous serial line, idle high.
REQ-008 rx_ready  input  1  consumer accepts rx_data when high together with rx_valid.
REQ-009 rx_data  output  8  received byte, LSB first on the line.
REQ-010 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-011 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 overrun  output  1  one-cycle pulse: new byte lost because the holding register was full.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use, and both flops SHALL reset to 1.
REQ-015 Tick divider SHALL count 0..CLK_DIV-1 and pulse tick for one cycle at CLK_DIV-1, giving a period of exactly CLK_DIV cycles.
REQ-016 The FSM SHALL have states IDLE, START, DATA and STOP, with a 4-bit sample counter s_cnt and a 3-bit bit counter b_cnt.
REQ-017 IDLE: on a tick with rx_s=0, the FSM SHALL go to START with s_cnt=0.
REQ-018 START: on a tick with s_cnt=7, the FSM SHALL go to DATA with s_cnt=0 and b_cnt=0 if rx_s=0; otherwise it SHALL treat the start as false and return to IDLE with no outputs.
REQ-019 DATA: on a tick with s_cnt=15, the FSM SHALL shift rx_s into shift[7] (right shift) and set s_cnt=0; if b_cnt=7 it SHALL go to STOP, otherwise it SHALL increment b_cnt.
REQ-020 STOP: on a tick with s_cnt=15, the FSM SHALL return to IDLE; if rx_s=1 it SHALL deliver the byte, otherwise it SHALL pulse frame_err and discard the byte.
REQ-021 In all states, on a tick not matching the above, s_cnt SHALL increment; s_cnt SHALL hold between ticks.
REQ-022 Delivery with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle, SHALL load rx_data and leave rx_valid=1.
REQ-023 Delivery with rx_valid=1 and rx_ready=0 SHALL pulse overrun, keep the old rx_data and leave rx_valid=1.
REQ-024 rx_valid=1 and rx_ready=1 with no delivery SHALL clear rx_valid on the next edge; rx_data SHALL hold its value.
REQ-025 rx_data and rx_valid SHALL remain stable while rx_valid=1 and rx_ready=0.
REQ-026 A frame error SHALL NOT alter rx_data or rx_valid.
REQ-027 The latency from the stop-bit mid-sample tick to rx_valid or frame_err SHALL be 1 clk2 cycle (registered).

Reset
REQ-028 On rst=1 at a clk2 edge, the FSM SHALL go to IDLE and the tick divider, s_cnt, b_cnt and shift SHALL clear to 0.
REQ-029 On reset, rx_data SHALL be 8'h00 and rx_valid, frame_err, overrun and busy SHALL be 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no pulse, and reception SHALL resume on the next start bit after rst deasserts.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3) and the OVERSAMPLE default.
REQ-032 The tick divider SHALL be a sub-module named uart_rx_tick (inputs clk2, rst; output tick; parameter CLK_DIV).
REQ-033 All remaining logic SHALL reside in uart_rx; no latches, and no asynchronous logic other than the rx input.

Verification (40 MHz, 115200 baud, CLK_DIV=21, bit period 336 cycles)
REQ-034 Send 0xA5, 8N1, rx_ready=1 -> rx_valid=1 with rx_data=8'hA5 within 9.5 bit periods +/- 2 ticks of the start edge, cleared 1 cycle later.
REQ-035 Send 0x3C then 0xC3 back-to-back with rx_ready=0 -> rx_data=8'h3C held, overrun pulses once, rx_valid stays 1; raising rx_ready then clears rx_valid.
REQ-036 Send 0x55 with a low stop bit -> frame_err pulses once, rx_valid stays 0, and the next good byte 0x0F is received correctly.
REQ-037 Apply a 4-tick low glitch on idle rx -> no rx_valid, no frame_err, and busy returns to 0 after the false start.
REQ-038 Assert rst for 1 cycle midway through bit 4 of 0xFF -> no outputs for that frame; the following 0x81 is received as 8'h81.
REQ-039 Send 0xA5, then pulse rx_ready in the same cycle a second byte 0x5A is delivered -> rx_data=8'h5A, rx_valid=1, no overrun.
